io_controller: RTL and testbench

Parametrised processor I/O subsystem that replaces the fixed switch-input and 4-digit display-output path of the single-cycle processor top level. It serves processor IN requests by waiting for a debounced "enter" press and capturing the switches. It serves OUT requests with a sequential binary-to-BCD conversion driving DIGITS seven-segment displays, with sign, overflow and leading-zero handling. It sits between the processor core and the board pins.

---
 rtl/io_controller.sv | 236 +++++++++++++++++++++++
 tb/tb_io_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_controller.sv
// Processor I/O subsystem: debounced enter-key switch capture for IN requests and
// sequential binary-to-BCD conversion driving seven-segment displays for OUT requests.
module io_controller #(
    parameter int DATA_W       = 32,
    parameter int SW_W         = 15,
    parameter int DIGITS       = 4,
    parameter int SIGNED       = 1,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enter,
    input  logic [SW_W-1:0]       switches,
    input  logic                  in_req,
    output logic                  in_ready,
    output logic [DATA_W-1:0]     in_data,
    input  logic                  out_req,
    input  logic [DATA_W-1:0]     out_value,
    output logic                  out_busy,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  neg,
    output logic                  ovf
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SEG_W = 7 * DIGITS;

    typedef enum logic {I_IDLE, I_WAIT} in_state_t;
    typedef enum logic [1:0] {O_IDLE, O_LOAD, O_SHIFT, O_DONE} out_state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // ---------------- enter synchroniser and debouncer ----------------
    logic            sync1_reg, sync2_reg;
    logic            db_level_reg, db_level_next;
    logic            db_prev_reg;
    logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
    logic            press;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            db_level_reg <= 1'b1;
            db_prev_reg  <= 1'b1;
            db_cnt_reg   <= '0;
        end else begin
            sync1_reg    <= enter;
            sync2_reg    <= sync1_reg;
            db_level_reg <= db_level_next;
            db_prev_reg  <= db_level_reg;
            db_cnt_reg   <= db_cnt_next;
        end
    end

    always_comb begin
        db_level_next = db_level_reg;
        db_cnt_next   = '0;
        if (sync2_reg != db_level_reg) begin
            if (db_cnt_reg == DB_W'(DEBOUNCE_CYC - 1)) begin
                db_level_next = sync2_reg;
            end else begin
                db_cnt_next = db_cnt_reg + 1'b1;
            end
        end
    end

    // Falling edge of the debounced (active-low) level marks one press.
    assign press = db_prev_reg & ~db_level_reg;

    // ---------------- input FSM ----------------
    in_state_t         istate_reg, istate_next;
    logic              in_ready_reg, in_ready_next;
    logic [DATA_W-1:0] in_data_reg, in_data_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            istate_reg   <= I_IDLE;
            in_ready_reg <= 1'b0;
            in_data_reg  <= '0;
        end else begin
            istate_reg   <= istate_next;
            in_ready_reg <= in_ready_next;
            in_data_reg  <= in_data_next;
        end
    end

    always_comb begin
        istate_next   = istate_reg;
        in_ready_next = 1'b0;
        in_data_next  = in_data_reg;
        case (istate_reg)
            I_IDLE: begin
                if (in_req) istate_next = I_WAIT;
            end
            I_WAIT: begin
                if (press) begin
                    in_data_next  = DATA_W'(switches);
                    in_ready_next = 1'b1;
                    istate_next   = I_IDLE;
                end else if (!in_req) begin
                    istate_next = I_IDLE;
                end
            end
            default: istate_next = I_IDLE;
        endcase
    end

    assign in_ready = in_ready_reg;
    assign in_data  = in_data_reg;

    // ---------------- output FSM and double-dabble converter ----------------
    out_state_t        ostate_reg, ostate_next;
    logic [DATA_W-1:0] value_reg, value_next;
    logic [DATA_W-1:0] mag_reg, mag_next;
    logic [BCD_W-1:0]  bcd_reg, bcd_next;
    logic [BCD_W-1:0]  bcd_adj;
    logic [CNT_W-1:0]  shift_cnt_reg, shift_cnt_next;
    logic              neg_acc_reg, neg_acc_next;
    logic              ovf_acc_reg, ovf_acc_next;
    logic [SEG_W-1:0]  seg_reg, seg_next;
    logic              neg_reg, neg_next;
    logic              ovf_reg, ovf_next;
    logic [SEG_W-1:0]  disp_seg;
    logic [DIGITS:0]   nz_chain;
    logic              is_neg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ostate_reg    <= O_IDLE;
            value_reg     <= '0;
            mag_reg       <= '0;
            bcd_reg       <= '0;
            shift_cnt_reg <= '0;
            neg_acc_reg   <= 1'b0;
            ovf_acc_reg   <= 1'b0;
            seg_reg       <= '1;
            neg_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            ostate_reg    <= ostate_next;
            value_reg     <= value_next;
            mag_reg       <= mag_next;
            bcd_reg       <= bcd_next;
            shift_cnt_reg <= shift_cnt_next;
            neg_acc_reg   <= neg_acc_next;
            ovf_acc_reg   <= ovf_acc_next;
            seg_reg       <= seg_next;
            neg_reg       <= neg_next;
            ovf_reg       <= ovf_next;
        end
    end

    assign nz_chain[DIGITS] = 1'b0;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] dig;
            logic       show;
            assign dig              = bcd_reg[4*gi +: 4];
            assign bcd_adj[4*gi +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
            assign nz_chain[gi]     = (dig != 4'd0) | nz_chain[gi+1];
            // Digit 0 always shows so a zero value displays "0", not blank.
            assign show             = (gi == 0) ? 1'b1 : nz_chain[gi];
            assign disp_seg[7*gi +: 7] = ovf_acc_reg ? 7'b0111111 :
                                         (show ? seg7(dig) : 7'h7F);
        end
    endgenerate

    assign is_neg = (SIGNED != 0) && value_reg[DATA_W-1];

    always_comb begin
        ostate_next    = ostate_reg;
        value_next     = value_reg;
        mag_next       = mag_reg;
        bcd_next       = bcd_reg;
        shift_cnt_next = shift_cnt_reg;
        neg_acc_next   = neg_acc_reg;
        ovf_acc_next   = ovf_acc_reg;
        seg_next       = seg_reg;
        neg_next       = neg_reg;
        ovf_next       = ovf_reg;
        case (ostate_reg)
            O_IDLE: begin
                if (out_req) begin
                    value_next  = out_value;
                    ostate_next = O_LOAD;
                end
            end
            O_LOAD: begin
                // Negating the most-negative value yields its correct unsigned magnitude.
                mag_next       = is_neg ? (~value_reg + 1'b1) : value_reg;
                neg_acc_next   = is_neg;
                bcd_next       = '0;
                shift_cnt_next = '0;
                ovf_acc_next   = 1'b0;
                ostate_next    = O_SHIFT;
            end
            O_SHIFT: begin
                ovf_acc_next          = ovf_acc_reg | bcd_adj[BCD_W-1];
                {bcd_next, mag_next}  = {bcd_adj[BCD_W-2:0], mag_reg, 1'b0};
                shift_cnt_next        = shift_cnt_reg + 1'b1;
                if (shift_cnt_reg == CNT_W'(DATA_W - 1)) ostate_next = O_DONE;
            end
            O_DONE: begin
                seg_next    = disp_seg;
                neg_next    = neg_acc_reg;
                ovf_next    = ovf_acc_reg;
                ostate_next = O_IDLE;
            end
            default: ostate_next = O_IDLE;
        endcase
    end

    assign out_busy = (ostate_reg != O_IDLE);
    assign seg      = seg_reg;
    assign neg      = neg_reg;
    assign ovf      = ovf_reg;

endmodule

// File: tb/tb_io_controller.sv
// Scoreboard bench for io_controller: display and capture expectations are queued
// when stimulus is driven and compared when the DUT completes each transaction.
module tb_io_controller;

    localparam int DATA_W = 16;
    localparam int SW_W   = 15;
    localparam int DIGITS = 4;
    localparam int DEB    = 4;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                enter = 1'b1;
    logic [SW_W-1:0]     switches = '0;
    logic                in_req = 1'b0;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic                out_req = 1'b0;
    logic [DATA_W-1:0]   out_value = '0;
    logic                out_busy;
    logic [7*DIGITS-1:0] seg;
    logic                neg;
    logic                ovf;

    io_controller #(
        .DATA_W(DATA_W), .SW_W(SW_W), .DIGITS(DIGITS), .SIGNED(1), .DEBOUNCE_CYC(DEB)
    ) dut (
        .clock(clock), .reset(reset), .enter(enter), .switches(switches),
        .in_req(in_req), .in_ready(in_ready), .in_data(in_data),
        .out_req(out_req), .out_value(out_value), .out_busy(out_busy),
        .seg(seg), .neg(neg), .ovf(ovf)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7*DIGITS-1:0] seg;
        logic                neg;
        logic                ovf;
    } out_exp_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } in_exp_t;

    out_exp_t out_q[$];
    in_exp_t  in_q[$];
    out_exp_t last_exp;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_len = 0;
    logic busy_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [6:0] code(input int d);
        case (d)
            0: code = 7'h40;  1: code = 7'h79;  2: code = 7'h24;  3: code = 7'h30;
            4: code = 7'h19;  5: code = 7'h12;  6: code = 7'h02;  7: code = 7'h78;
            8: code = 7'h00;  9: code = 7'h10;
            default: code = 7'h7F;
        endcase
    endfunction

    function automatic out_exp_t model(input logic [DATA_W-1:0] v);
        out_exp_t e;
        int mag;
        int p;
        mag   = int'(v);
        e.neg = v[DATA_W-1];
        if (e.neg) mag = 65536 - mag;
        e.ovf = (mag > 9999);
        p = 1;
        for (int d = 0; d < DIGITS; d++) begin
            if (e.ovf)                  e.seg[7*d +: 7] = 7'h3F;
            else if (d == 0 || mag >= p) e.seg[7*d +: 7] = code((mag / p) % 10);
            else                        e.seg[7*d +: 7] = 7'h7F;
            p = p * 10;
        end
        return e;
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    always begin
        @(posedge clock);
        cyc++;
        #1;
        if (reset) begin
            busy_prev = 1'b0;
            busy_len  = 0;
        end else begin
            if (out_busy) busy_len++;
            if (busy_prev && !out_busy) begin
                check("out_pending", out_q.size() > 0, 1'b1);
                if (out_q.size() > 0) begin
                    out_exp_t e;
                    e = out_q.pop_front();
                    $display("out done: seg=%h neg=%b ovf=%b busy=%0d", seg, neg, ovf, busy_len);
                    check("seg", seg, e.seg);
                    check("neg", neg, e.neg);
                    check("ovf", ovf, e.ovf);
                    check("busy_len", busy_len, DATA_W + 2);
                end
                busy_len = 0;
            end
            busy_prev = out_busy;
            if (in_ready) begin
                check("in_pending", in_q.size() > 0, 1'b1);
                if (in_q.size() > 0) begin
                    in_exp_t ie;
                    ie = in_q.pop_front();
                    $display("in ready: data=%h cycle=%0d", in_data, cyc);
                    check("in_data", in_data, ie.data);
                    check("in_latency", cyc, ie.cyc);
                end
            end
        end
    end

    task automatic send_out(input logic [DATA_W-1:0] v, input bit expect_accept);
        @(negedge clock);
        out_value = v;
        out_req   = 1'b1;
        if (expect_accept) begin
            last_exp = model(v);
            out_q.push_back(last_exp);
        end
        @(negedge clock);
        out_req = 1'b0;
    endtask

    task automatic press_low(input logic [SW_W-1:0] sw);
        @(negedge clock);
        switches = sw;
        enter    = 1'b0;
        in_q.push_back('{data: DATA_W'(sw), cyc: cyc + DEB + 3});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((out_q.size() + in_q.size()) != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check(tag, out_q.size() + in_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_in_data"},  in_data, '0);
        check({tag, "_busy"},     out_busy, 1'b0);
        check({tag, "_seg"},      seg, {7*DIGITS{1'b1}});
        check({tag, "_neg"},      neg, 1'b0);
        check({tag, "_ovf"},      ovf, 1'b0);
    endtask

    initial begin
        // 1. Reset asserted mid-cycle.
        repeat (3) @(negedge clock);
        @(posedge clock);
        #3 reset = 1'b1;
        #1 check_reset_outputs("rst");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("idle_seg", seg, 28'hFFFFFFF);
        check("idle_busy", out_busy, 1'b0);

        // 2. Basic display.
        send_out(16'd1234, 1'b1);
        drain("drain_1234");

        // 3. Negative with blanking, then most-negative value.
        send_out(16'hFFF9, 1'b1);
        drain("drain_m7");
        send_out(16'h8000, 1'b1);
        drain("drain_8000");

        // 4. Overflow, with a second request that must be ignored.
        send_out(16'd12345, 1'b1);
        repeat (3) @(negedge clock);
        send_out(16'd42, 1'b0);
        drain("drain_12345");
        repeat (25) @(negedge clock);
        check("seg_hold", seg, last_exp.seg);
        check("ovf_hold", ovf, last_exp.ovf);

        // 5. Debounce: short glitch ignored, held press captured once.
        @(negedge clock);
        in_req   = 1'b1;
        switches = 15'h01A5;
        repeat (2) @(negedge clock);
        enter = 1'b0;
        repeat (2) @(negedge clock);
        enter = 1'b1;
        repeat (12) @(negedge clock);
        press_low(15'h01A5);
        drain("drain_press");
        repeat (20) @(negedge clock);
        check("in_data_hold", in_data, 16'h01A5);
        enter = 1'b1;
        repeat (15) @(negedge clock);

        // 6. Reset during SHIFT with a press in progress.
        @(negedge clock);
        out_value = 16'd1234;
        out_req   = 1'b1;
        out_q.push_back(model(16'd1234));
        enter     = 1'b0;
        @(negedge clock);
        out_req = 1'b0;
        repeat (3) @(negedge clock);
        @(posedge clock);
        #3 reset = 1'b1;
        out_q.delete();
        in_q.delete();
        #1 check_reset_outputs("rst_mid");
        @(negedge clock);
        enter = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (12) @(negedge clock);
        send_out(16'd9, 1'b1);
        drain("drain_9");
        check("seg_9", seg, {7'h7F, 7'h7F, 7'h7F, 7'h10});
        press_low(15'h7FFF);
        drain("drain_press2");
        enter  = 1'b1;
        in_req = 1'b0;
        repeat (10) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
